// File: rtl/arp_mac_resolver_if.sv
// Request/result, ARP-table seek and ARP-request trigger signals of the MAC resolver.
// master drives requests and table responses; slave is the resolver itself.
interface arp_mac_resolver_if;
   logic [31:0] req_ip;
   logic        req_valid;
   logic        req_ready;
   logic [47:0] resolved_mac;
   logic [31:0] resolved_ip;
   logic        resolved_valid;
   logic        resolve_fail;
   logic        cache_flush;
   logic [31:0] seek_ip;
   logic        seek_valid;
   logic [47:0] seek_mac;
   logic        seek_mac_valid;
   logic        arp_active;
   logic [31:0] arp_active_dst_ip;

   modport master (
      output req_ip, req_valid, cache_flush, seek_mac, seek_mac_valid,
      input  req_ready, resolved_mac, resolved_ip, resolved_valid, resolve_fail,
      input  seek_ip, seek_valid, arp_active, arp_active_dst_ip
   );

   modport slave (
      input  req_ip, req_valid, cache_flush, seek_mac, seek_mac_valid,
      output req_ready, resolved_mac, resolved_ip, resolved_valid, resolve_fail,
      output seek_ip, seek_valid, arp_active, arp_active_dst_ip
   );
endinterface

// File: rtl/arp_mac_resolver.sv
// Resolves a destination IP to a MAC via ARP-table seeks, ARP requests with bounded
// retries, a one-entry last-hit cache and direct broadcast handling.
module arp_mac_resolver #(
   parameter int unsigned P_RETRY_MAX    = 3,
   parameter int unsigned P_WAIT_CYCLES  = 156250,
   parameter int unsigned P_SEEK_TIMEOUT = 16
) (
   input logic               clk,
   input logic               rst,
   arp_mac_resolver_if.slave bus
);
   localparam int unsigned      CntW     = 24;
   localparam logic [CntW-1:0]  WaitLoad = CntW'(P_WAIT_CYCLES - 1);
   localparam logic [CntW-1:0]  SeekLast = CntW'(P_SEEK_TIMEOUT - 1);
   localparam logic [CntW-1:0]  CntOne   = CntW'(1);
   localparam logic [3:0]       RetryMax = 4'(P_RETRY_MAX);
   localparam logic [31:0]      BcastIp  = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      StIdle, StSeek, StWaitSeek, StArpReq, StWaitArp, StDone, StFail
   } state_e;

   state_e          state_q, state_d;
   logic [31:0]     ip_q, ip_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      retry_q, retry_d;
   logic            cache_valid_q, cache_valid_d;
   logic [31:0]     cache_ip_q, cache_ip_d;
   logic [47:0]     cache_mac_q, cache_mac_d;
   logic [47:0]     done_mac;
   logic            miss;
   logic            accept;

   logic            req_ready_q, req_ready_d;
   logic [47:0]     resolved_mac_q, resolved_mac_d;
   logic [31:0]     resolved_ip_q, resolved_ip_d;
   logic            resolved_valid_q, resolved_valid_d;
   logic            resolve_fail_q, resolve_fail_d;
   logic [31:0]     seek_ip_q, seek_ip_d;
   logic            seek_valid_q, seek_valid_d;
   logic            arp_active_q, arp_active_d;
   logic [31:0]     arp_ip_q, arp_ip_d;

   assign accept = bus.req_valid & req_ready_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= StIdle;
         ip_q             <= '0;
         cnt_q            <= '0;
         retry_q          <= '0;
         cache_valid_q    <= 1'b0;
         cache_ip_q       <= '0;
         cache_mac_q      <= '0;
         req_ready_q      <= 1'b1;
         resolved_mac_q   <= '0;
         resolved_ip_q    <= '0;
         resolved_valid_q <= 1'b0;
         resolve_fail_q   <= 1'b0;
         seek_ip_q        <= '0;
         seek_valid_q     <= 1'b0;
         arp_active_q     <= 1'b0;
         arp_ip_q         <= '0;
      end else begin
         state_q          <= state_d;
         ip_q             <= ip_d;
         cnt_q            <= cnt_d;
         retry_q          <= retry_d;
         cache_valid_q    <= cache_valid_d;
         cache_ip_q       <= cache_ip_d;
         cache_mac_q      <= cache_mac_d;
         req_ready_q      <= req_ready_d;
         resolved_mac_q   <= resolved_mac_d;
         resolved_ip_q    <= resolved_ip_d;
         resolved_valid_q <= resolved_valid_d;
         resolve_fail_q   <= resolve_fail_d;
         seek_ip_q        <= seek_ip_d;
         seek_valid_q     <= seek_valid_d;
         arp_active_q     <= arp_active_d;
         arp_ip_q         <= arp_ip_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ip_d          = ip_q;
      cnt_d         = cnt_q;
      retry_d       = retry_q;
      cache_valid_d = cache_valid_q;
      cache_ip_d    = cache_ip_q;
      cache_mac_d   = cache_mac_q;
      done_mac      = cache_mac_q;
      miss          = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               ip_d    = bus.req_ip;
               retry_d = '0;
               if (bus.req_ip == BcastIp) begin
                  state_d  = StDone;
                  done_mac = '1;
               // a flush arriving with the request already counts as a miss
               end else if (cache_valid_q && !bus.cache_flush && cache_ip_q == bus.req_ip) begin
                  state_d  = StDone;
                  done_mac = cache_mac_q;
               end else begin
                  state_d = StSeek;
               end
            end
         end
         StSeek: begin
            cnt_d   = '0;
            state_d = StWaitSeek;
         end
         StWaitSeek: begin
            if (bus.seek_mac_valid) begin
               if (bus.seek_mac != '0) begin
                  state_d       = StDone;
                  done_mac      = bus.seek_mac;
                  cache_valid_d = 1'b1;
                  cache_ip_d    = ip_q;
                  cache_mac_d   = bus.seek_mac;
               end else begin
                  miss = 1'b1;
               end
            end else if (cnt_q == SeekLast) begin
               miss = 1'b1;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
            if (miss) state_d = (retry_q < RetryMax) ? StArpReq : StFail;
         end
         StArpReq: begin
            retry_d = retry_q + 4'd1;
            cnt_d   = WaitLoad;
            state_d = StWaitArp;
         end
         StWaitArp: begin
            if (cnt_q == '0) state_d = StSeek;
            else cnt_d = cnt_q - CntOne;
         end
         StDone, StFail: begin
            retry_d = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (bus.cache_flush) cache_valid_d = 1'b0;
   end

   // Outputs are decoded from the next state so every port comes straight from a flop.
   always_comb begin
      req_ready_d      = (state_d == StIdle);
      resolved_valid_d = (state_d == StDone);
      resolve_fail_d   = (state_d == StFail);
      seek_valid_d     = (state_d == StSeek);
      arp_active_d     = (state_d == StArpReq);
      resolved_mac_d   = resolved_valid_d ? done_mac : resolved_mac_q;
      resolved_ip_d    = (resolved_valid_d || resolve_fail_d) ? ip_d : resolved_ip_q;
      seek_ip_d        = seek_valid_d ? ip_d : seek_ip_q;
      arp_ip_d         = arp_active_d ? ip_d : arp_ip_q;
   end

   assign bus.req_ready         = req_ready_q;
   assign bus.resolved_mac      = resolved_mac_q;
   assign bus.resolved_ip       = resolved_ip_q;
   assign bus.resolved_valid    = resolved_valid_q;
   assign bus.resolve_fail      = resolve_fail_q;
   assign bus.seek_ip           = seek_ip_q;
   assign bus.seek_valid        = seek_valid_q;
   assign bus.arp_active        = arp_active_q;
   assign bus.arp_active_dst_ip = arp_ip_q;
endmodule

// File: tb/tb_arp_mac_resolver.sv
// Bench for arp_mac_resolver: a timeline model predicts every pulse and held value from the
// per-seek table-response plan; directed scenarios first, then randomized traffic.
module tb_arp_mac_resolver;
   localparam int RetryMax    = 3;
   localparam int WaitCycles  = 100;
   localparam int SeekTimeout = 16;
   localparam logic [31:0] Bcast = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   arp_mac_resolver_if bus ();

   arp_mac_resolver #(
      .P_RETRY_MAX   (RetryMax),
      .P_WAIT_CYCLES (WaitCycles),
      .P_SEEK_TIMEOUT(SeekTimeout)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model: expected pulse cycles, seek windows and scheduled table responses
   bit          exp_seek[int], exp_arp[int], exp_done[int], exp_fail[int], ws[int];
   bit          resp_v[int];
   logic [47:0] resp_mac[int];
   int          busy_from = -1, busy_to = -1;
   logic [31:0] txn_ip = '0;
   logic [47:0] txn_mac = '0;
   logic [47:0] cur_mac = '0;
   logic [31:0] cur_res_ip = '0, cur_seek_ip = '0, cur_arp_ip = '0;
   bit          m_cv = 1'b0;
   logic [31:0] m_cip = '0, load_ip = '0;
   logic [47:0] m_cmac = '0, load_mac = '0;
   int          load_cyc = -1;
   int          plan_d[4];
   logic [47:0] plan_mac[4];
   bit          chk_en = 1'b0;
   bit          accepted;
   int          acc_cyc;
   int          n_seek = 0, n_arp = 0, n_done = 0, n_fail = 0;
   int          last_seek_cyc = 0, last_arp_cyc = 0, last_done_cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         bit e_s, e_a, e_d, e_f;
         e_s = exp_seek.exists(cyc);
         e_a = exp_arp.exists(cyc);
         e_d = exp_done.exists(cyc);
         e_f = exp_fail.exists(cyc);
         if (e_s) cur_seek_ip = txn_ip;
         if (e_a) cur_arp_ip = txn_ip;
         if (e_d) begin cur_mac = txn_mac; cur_res_ip = txn_ip; end
         if (e_f) cur_res_ip = txn_ip;
         chk("req_ready", bus.req_ready, !(cyc >= busy_from && cyc <= busy_to));
         chk("seek_valid", bus.seek_valid, e_s);
         chk("arp_active", bus.arp_active, e_a);
         chk("resolved_valid", bus.resolved_valid, e_d);
         chk("resolve_fail", bus.resolve_fail, e_f);
         chk("resolved_mac", bus.resolved_mac, cur_mac);
         chk("resolved_ip", bus.resolved_ip, cur_res_ip);
         chk("seek_ip", bus.seek_ip, cur_seek_ip);
         chk("arp_dst_ip", bus.arp_active_dst_ip, cur_arp_ip);
         if (bus.seek_valid) begin n_seek++; last_seek_cyc = cyc; end
         if (bus.arp_active) begin n_arp++; last_arp_cyc = cyc; end
         if (bus.resolved_valid) begin n_done++; last_done_cyc = cyc; end
         if (bus.resolve_fail) n_fail++;
      end
   end

   // Lays out the whole transaction timeline from the accept cycle and the response plan.
   task automatic plan(input logic [31:0] ip, input bit flush);
      int s, d, dd, k, retry;
      logic [47:0] m;
      txn_ip    = ip;
      busy_from = cyc + 1;
      if (ip == Bcast || (m_cv && !flush && m_cip == ip)) begin
         txn_mac = (ip == Bcast) ? 48'hFFFF_FFFF_FFFF : m_cmac;
         busy_to = cyc + 1;
         exp_done[cyc + 1] = 1'b1;
         return;
      end
      s = cyc + 1; retry = 0; k = 0;
      while (1) begin
         exp_seek[s] = 1'b1;
         d = plan_d[k];
         m = plan_mac[k];
         if (d != 0) begin
            resp_v[s + d] = 1'b1;
            resp_mac[s + d] = m;
            dd = s + d + 1;
         end else begin
            dd = s + SeekTimeout + 1;
         end
         for (int c = s; c < dd; c++) ws[c] = 1'b1;
         if (d != 0 && m != '0) begin
            txn_mac = m; exp_done[dd] = 1'b1; busy_to = dd;
            load_cyc = s + d; load_ip = ip; load_mac = m;
            return;
         end
         if (retry < RetryMax) begin
            exp_arp[dd] = 1'b1; retry++; k++;
            s = dd + WaitCycles + 1;
         end else begin
            exp_fail[dd] = 1'b1; busy_to = dd;
            return;
         end
      end
   endtask

   task automatic step(input bit do_req, input logic [31:0] ip, input bit flush, input bit noise);
      @(posedge clk);
      #1;
      bus.req_valid      = 1'b0;
      bus.req_ip         = $urandom;
      bus.cache_flush    = flush;
      bus.seek_mac_valid = 1'b0;
      bus.seek_mac       = 48'({$urandom, $urandom});
      if (cyc > busy_to) begin
         if (do_req) begin
            bus.req_valid = 1'b1;
            bus.req_ip    = ip;
            accepted      = 1'b1;
            acc_cyc       = cyc;
            plan(ip, flush);
         end
      end else if (noise && $urandom_range(0, 3) == 0) begin
         bus.req_valid = 1'b1;
      end
      if (resp_v.exists(cyc)) begin
         bus.seek_mac_valid = 1'b1;
         bus.seek_mac       = resp_mac[cyc];
      end else if (noise && !ws.exists(cyc) && $urandom_range(0, 7) == 0) begin
         bus.seek_mac_valid = 1'b1;
      end
      if (flush) m_cv = 1'b0;
      else if (cyc == load_cyc) begin m_cv = 1'b1; m_cip = load_ip; m_cmac = load_mac; end
   endtask

   task automatic request(input logic [31:0] ip, input bit flush, input bit noise);
      int guard = 0;
      accepted = 1'b0;
      while (!accepted && guard < 2000) begin
         step(1'b1, ip, flush, noise);
         guard++;
      end
      if (!accepted) chk("request_accept_bound", 0, 1);
   endtask

   task automatic idle(input int n, input bit noise);
      repeat (n) step(1'b0, '0, noise && ($urandom_range(0, 15) == 0), noise);
   endtask

   task automatic drain();
      int guard = 0;
      while (cyc <= busy_to + 1 && guard < 2000) begin idle(1, 1'b0); guard++; end
      if (guard >= 2000) chk("drain_bound", 0, 1);
   endtask

   task automatic model_reset();
      exp_seek.delete(); exp_arp.delete(); exp_done.delete(); exp_fail.delete();
      ws.delete(); resp_v.delete(); resp_mac.delete();
      busy_from = -1; busy_to = -1; load_cyc = -1; m_cv = 1'b0;
      cur_mac = '0; cur_res_ip = '0; cur_seek_ip = '0; cur_arp_ip = '0;
   endtask

   task automatic set_plan(input int d0, input logic [47:0] m0, input int d1,
                           input logic [47:0] m1);
      plan_d[0] = d0; plan_mac[0] = m0; plan_d[1] = d1; plan_mac[1] = m1;
      plan_d[2] = 1;  plan_mac[2] = '0; plan_d[3] = 1;  plan_mac[3] = '0;
   endtask

   initial begin
      int n0, a0, f0, d0;
      logic [31:0] pool[4];
      bus.req_valid = 1'b0; bus.req_ip = '0; bus.cache_flush = 1'b0;
      bus.seek_mac = '0; bus.seek_mac_valid = 1'b0;
      pool[0] = 32'hC0A8_0001; pool[1] = 32'hC0A8_0002; pool[2] = 32'hC0A8_0003; pool[3] = Bcast;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", bus.req_ready, 1);
      chk("reset_resolved_valid", bus.resolved_valid, 0);
      chk("reset_seek_valid", bus.seek_valid, 0);
      chk("reset_arp_active", bus.arp_active, 0);
      chk("reset_resolved_mac", bus.resolved_mac, 0);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      // Broadcast
      n0 = n_seek; a0 = n_arp;
      request(Bcast, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("bcast_latency", last_done_cyc - acc_cyc, 1);
      chk("bcast_mac", bus.resolved_mac, 48'hFFFF_FFFF_FFFF);
      chk("bcast_no_seek", n_seek - n0 + n_arp - a0, 0);

      // Table hit three cycles after the seek, then a cache hit
      set_plan(3, 48'hA0B1_C2D3_E4F5, 1, '0);
      request(32'hC0A8_6464, 1'b0, 1'b0);
      idle(8, 1'b0);
      chk("hit_latency", last_done_cyc - acc_cyc, 5);
      chk("hit_mac", bus.resolved_mac, 48'hA0B1_C2D3_E4F5);
      n0 = n_seek;
      request(32'hC0A8_6464, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("cache_latency", last_done_cyc - acc_cyc, 1);
      chk("cache_no_seek", n_seek - n0, 0);

      // Flush after a cached hit forces a fresh seek
      idle(1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      n0 = n_seek;
      set_plan(2, 48'hA0B1_C2D3_E4F5, 1, '0);
      request(32'hC0A8_6464, 1'b0, 1'b0);
      drain();
      chk("flush_reseek", n_seek - n0, 1);

      // Flush in the accept cycle
      n0 = n_seek;
      request(32'hC0A8_6464, 1'b1, 1'b0);
      drain();
      chk("flush_on_accept_seek", n_seek - n0, 1);

      // Miss then learn
      set_plan(2, '0, 5, 48'h1122_3344_5566);
      request(32'hC0A8_6432, 1'b0, 1'b0);
      drain();
      chk("learn_reseek_gap", last_seek_cyc - last_arp_cyc, 101);
      chk("learn_arp_ip", bus.arp_active_dst_ip, 32'hC0A8_6432);
      chk("learn_mac", bus.resolved_mac, 48'h1122_3344_5566);

      // Total failure
      n0 = n_seek; a0 = n_arp; f0 = n_fail; d0 = n_done;
      set_plan(1, '0, 4, '0);
      request(32'h0A00_0001, 1'b0, 1'b0);
      drain();
      chk("fail_arp_count", n_arp - a0, 3);
      chk("fail_seek_count", n_seek - n0, 4);
      chk("fail_pulse_count", (n_fail - f0) * 2 + (n_done - d0), 2);
      chk("fail_ip", bus.resolved_ip, 32'h0A00_0001);
      chk("fail_ready_after", bus.req_ready, 1);

      // Seek timeout with a late response during the ARP wait
      set_plan(0, '0, 4, 48'h0102_0304_0506);
      request(32'h0A00_0002, 1'b0, 1'b0);
      idle(22, 1'b0);
      chk("timeout_gap", last_arp_cyc - last_seek_cyc, 17);
      resp_v[cyc + 1] = 1'b1;
      resp_mac[cyc + 1] = 48'hDEAD_BEEF_0001;
      drain();
      chk("timeout_mac", bus.resolved_mac, 48'h0102_0304_0506);

      // Reset during the ARP wait
      set_plan(1, '0, 1, '0);
      request(32'h0A00_0003, 1'b0, 1'b0);
      idle(10, 1'b0);
      @(posedge clk);
      #1;
      chk_en = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_mid_ready", bus.req_ready, 1);
      chk("rst_mid_pulses", {bus.seek_valid, bus.arp_active, bus.resolved_valid,
                             bus.resolve_fail}, 0);
      chk("rst_mid_arp_ip", bus.arp_active_dst_ip, 0);
      chk("rst_mid_res_ip", bus.resolved_ip, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      // Randomized traffic with flushes, ignored requests and stray table responses
      for (int t = 0; t < 30; t++) begin
         for (int k = 0; k < 4; k++) begin
            plan_d[k]   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, SeekTimeout));
            plan_mac[k] = ($urandom_range(0, 2) == 0) ? (48'({$urandom, $urandom}) | 48'h1) : '0;
         end
         request(pool[$urandom_range(0, 3)], $urandom_range(0, 7) == 0, 1'b1);
         idle($urandom_range(0, 3), 1'b1);
      end
      drain();
      idle(2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/arp_mac_resolver.md
Name: arp_mac_resolver

Overview:
- Initiator side of the ARP block's seek/active-request interface; sits in the IP TX path ahead of Ethernet header insertion.
- Accepts a destination IP per outgoing frame and issues a table seek.
- On a miss, fires an ARP request, waits, and re-seeks with bounded retries.
- Returns the resolved MAC or a fail pulse; holds a one-entry last-hit cache and handles broadcast directly.

Parameters:
- P_RETRY_MAX, 3, number of ARP requests sent before declaring failure (1..15).
- P_WAIT_CYCLES, 156250, cycles waited after each ARP request before re-seeking (1 ms at 156.25 MHz); counter width 24 bits.
- P_SEEK_TIMEOUT, 16, cycles allowed for a seek response before treating it as a miss.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req_ip  in  32  destination IP to resolve
- i_req_valid  in  1  request strobe
- o_req_ready  out  1  high only in IDLE
- o_resolved_mac  out  48  resolved MAC, valid with o_resolved_valid
- o_resolved_ip  out  32  IP the result belongs to
- o_resolved_valid  out  1  one-cycle success pulse
- o_resolve_fail  out  1  one-cycle failure pulse; o_resolved_ip valid with it
- i_cache_flush  in  1  invalidates last-hit cache
- o_seek_ip  out  32  IP to the ARP table
- o_seek_valid  out  1  one-cycle seek strobe
- i_seek_mac  in  48  table response; 48'h0 = miss
- i_seek_mac_valid  in  1  table response strobe
- o_arp_active  out  1  one-cycle ARP request trigger
- o_arp_active_dst_ip  out  32  target IP of the ARP request

Behaviour:
- Reset values: all outputs 0, except o_req_ready = 1. Cache valid = 0, retry count = 0, FSM = IDLE.
- All outputs are registered. Reset mid-operation returns to IDLE immediately; any pending pulse is dropped.
- A request is accepted on i_req_valid & o_req_ready. The IP is latched and o_req_ready drops the next cycle.
- IDLE, on accept:
  - IP = 32'hFFFF_FFFF: o_resolved_valid with MAC 48'hFFFF_FFFF_FFFF, one cycle after accept (DONE). No seek is issued.
  - Else, cache valid and cache IP = request IP: o_resolved_valid with cached MAC, one cycle after accept.
  - Else: go to SEEK.
- SEEK (1 cycle): o_seek_valid = 1, o_seek_ip = latched IP. Clear the timeout counter, go to WAIT_SEEK.
- WAIT_SEEK:
  - i_seek_mac_valid with MAC != 0: HIT. Pulse o_resolved_valid the next cycle and load the cache {IP, MAC}.
  - i_seek_mac_valid with MAC = 0, or P_SEEK_TIMEOUT cycles elapse without a response: MISS.
  - i_seek_mac_valid outside WAIT_SEEK is ignored.
- MISS:
  - retry < P_RETRY_MAX: go to ARP_REQ.
  - Else: o_resolve_fail pulse the next cycle, then IDLE.
- ARP_REQ (1 cycle): o_arp_active = 1, o_arp_active_dst_ip = latched IP. Increment retry, load the wait counter with P_WAIT_CYCLES-1, go to WAIT_ARP.
- WAIT_ARP: count down to 0, then SEEK. Total delay from o_arp_active to the next o_seek_valid = P_WAIT_CYCLES+1 cycles.
- DONE / FAIL: one cycle, outputs pulse, retry cleared, then IDLE. o_req_ready returns high in the cycle after the pulse.
- Cache flush:
  - i_cache_flush clears cache valid in any state.
  - Flush in the same cycle as a cache load: flush wins.
  - Flush in the same cycle as a request accept: lookup uses the post-flush state (miss).
- A successful result never updates the cache for broadcast.
- o_resolved_mac / o_resolved_ip hold their last value between pulses.

Test Plan:
- Broadcast: request 255.255.255.255 → o_resolved_valid one cycle after accept, MAC FFFFFFFFFFFF, no o_seek_valid or o_arp_active.
- Table hit: request 192.168.100.100, table answers 3 cycles after seek with 48'hA0_B1_C2_D3_E4_F5 → one resolved pulse with that MAC. A repeat request hits the cache: pulse one cycle after accept, no seek.
- Miss then learn: request 192.168.100.50; first seek returns 0 → o_arp_active with dst 192.168.100.50; bench P_WAIT_CYCLES=100. Re-seek occurs exactly 101 cycles later and returns 48'h11_22_33_44_55_66 → resolved pulse, retry cleared.
- Total failure: P_RETRY_MAX=3, every seek returns 0 → exactly 3 o_arp_active pulses and 4 seeks, then o_resolve_fail with IP echoed, then ready=1.
- Seek timeout: table never responds → miss declared after 16 cycles, ARP request issued. A late i_seek_mac_valid during WAIT_ARP is ignored.
- Reset/flush: assert i_rst during WAIT_ARP → all outputs 0, ready=1 immediately. After a cached hit, pulse i_cache_flush → the next identical request issues o_seek_valid.
